// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory port arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_NREQ = 2;
  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 32;
  localparam int BE_W     = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after ptr, wrapping.
module dmem_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any_req
);

  int j;

  // Walk candidates from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = |req;
    j       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one registered data-memory port between NREQ requesters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*BE_W-1:0] req_we,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        daddr,
  output logic [DW-1:0]        dwdata,
  output logic [BE_W-1:0]      dwe,
  input  logic [DW-1:0]        drdata
);

  localparam int IW = $clog2(NREQ);

  state_t state, state_nx;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            any_req;
  logic            arb_en;

  logic [NREQ-1:0][AW-1:0]   addr_v;
  logic [NREQ-1:0][DW-1:0]   wdata_v;
  logic [NREQ-1:0][BE_W-1:0] we_v;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign we_v    = req_we;

  dmem_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // Arbitration is only legal while the port is free: closing edge of IDLE or RESP.
  always_comb begin
    state_nx = state;
    arb_en   = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (any_req) begin
          arb_en   = 1'b1;
          state_nx = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS:  state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ-1);
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      daddr  <= '0;
      dwdata <= '0;
      dwe    <= '0;
    end else begin
      state  <= state_nx;
      gnt    <= '0;
      rvalid <= '0;
      if (arb_en) begin
        gnt    <= win_oh;
        ptr    <= win_idx;
        daddr  <= addr_v[win_idx];
        dwdata <= wdata_v[win_idx];
        dwe    <= we_v[win_idx];
      end
      // gnt still names the winner during ACCESS; it becomes the rvalid pulse.
      if (state == ACCESS) begin
        rvalid <= gnt;
        rdata  <= (dwe == '0) ? drdata : '0;
        dwe    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: vector table, hand-written corner sequences, randomized traffic vs reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*4-1:0]    req_we;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        daddr;
  logic [DW-1:0]        dwdata;
  logic [3:0]           dwe;
  logic [DW-1:0]        drdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dwe       (dwe),
    .drdata    (drdata)
  );

  // Environment memory: 256 words, async read, byte-lane write, cleared by reset.
  logic [31:0] mem [0:255];
  assign drdata = mem[daddr[9:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dwe[b]) mem[daddr[9:2]][b*8 +: 8] <= dwdata[b*8 +: 8];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic on, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] we);
    req[i]                = on;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_we[i*4 +: 4]      = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  // Reference-model state for the randomized phase.
  logic [31:0]     ref_mem [0:255];
  logic [NREQ-1:0] snap_req, exp_g, exp_g_prev, exp_rv;
  logic [31:0]     snap_addr  [NREQ];
  logic [31:0]     snap_wdata [NREQ];
  logic [3:0]      snap_we    [NREQ];
  logic [31:0]     pend_rdata;
  logic [31:0]     ra;
  int              last, w, j, ngrant, first_w, gcyc;
  int              cnt [NREQ];
  bit              done;

  initial begin
    tbl[0] = '{0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    tbl[1] = '{0, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[2] = '{1, 32'h0000_0040, 32'h1234_5678, 4'b1111, 32'h0};
    tbl[3] = '{1, 32'h0000_0040, 32'h0,         4'b0000, 32'h1234_5678};
    tbl[4] = '{0, 32'h0000_0044, 32'hAABB_CCDD, 4'b0100, 32'h0};
    tbl[5] = '{1, 32'h0000_0044, 32'h0,         4'b0000, 32'h00BB_0000};
    tbl[6] = '{1, 32'h0000_0103, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[7] = '{0, 32'hFFFF_FF00, 32'h0,         4'b0000, 32'h0};

    do_reset();
    chk("rst_gnt",    32'(gnt),    0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata",  rdata,       0);
    chk("rst_daddr",  daddr,       0);
    chk("rst_dwdata", dwdata,      0);
    chk("rst_dwe",    32'(dwe),    0);

    // Simultaneous requests straight out of reset: 0 first, then 1.
    set_req(0, 1'b1, 32'h0, 32'h0, 4'b0);
    set_req(1, 1'b1, 32'h4, 32'h0, 4'b0);
    step(); chk("sim_c1_gnt", 32'(gnt), 32'b01);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'b0);
    step(); chk("sim_c2_gnt", 32'(gnt), 0); chk("sim_c2_rvalid", 32'(rvalid), 32'b01);
    chk("sim_c2_rdata", rdata, 0);
    step(); chk("sim_c3_gnt", 32'(gnt), 32'b10); chk("sim_c3_daddr", daddr, 32'h4);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'b0);
    step(); chk("sim_c4_rvalid", 32'(rvalid), 32'b10);
    step(); chk("sim_c5_rvalid", 32'(rvalid), 0); chk("sim_c5_gnt", 32'(gnt), 0);

    // Vector table: one transaction per row, started from IDLE.
    for (int r = 0; r < 8; r++) begin
      set_req(tbl[r].id, 1'b1, tbl[r].addr, tbl[r].wdata, tbl[r].we);
      step();
      chk($sformatf("vec%0d_gnt", r),    32'(gnt), 32'(1) << tbl[r].id);
      chk($sformatf("vec%0d_daddr", r),  daddr,    tbl[r].addr);
      chk($sformatf("vec%0d_dwdata", r), dwdata,   tbl[r].wdata);
      chk($sformatf("vec%0d_dwe", r),    32'(dwe), 32'(tbl[r].we));
      set_req(tbl[r].id, 1'b0, 32'h0, 32'h0, 4'b0);
      step();
      chk($sformatf("vec%0d_rvalid", r), 32'(rvalid), 32'(1) << tbl[r].id);
      chk($sformatf("vec%0d_rdata", r),  rdata,       tbl[r].exp_rdata);
      chk($sformatf("vec%0d_resp_dwe", r), 32'(dwe),  0);
      chk($sformatf("vec%0d_resp_daddr", r), daddr,   tbl[r].addr);
      step();
      chk($sformatf("vec%0d_idle_rvalid", r), 32'(rvalid), 0);
    end

    // Fairness: both requesting continuously for 20 grants.
    first_w = (tbl[7].id + 1) % NREQ;
    w       = first_w;
    ngrant  = 0;
    gcyc    = 0;
    cnt[0]  = 0;
    cnt[1]  = 0;
    set_req(0, 1'b1, 32'h8, 32'h0, 4'b0);
    set_req(1, 1'b1, 32'hC, 32'h0, 4'b0);
    for (int c = 1; c <= 60 && ngrant < 20; c++) begin
      step();
      if (gnt != '0) begin
        chk($sformatf("fair_g%0d", ngrant), 32'(gnt), 32'(1) << w);
        if (gnt[0]) cnt[0]++;
        if (gnt[1]) cnt[1]++;
        ngrant++;
        gcyc = c;
        w    = (w + 1) % NREQ;
      end
    end
    req = '0;
    chk("fair_total", 32'(ngrant), 20);
    chk("fair_cnt0",  32'(cnt[0]), 10);
    chk("fair_cnt1",  32'(cnt[1]), 10);
    chk("fair_last_cycle", 32'(gcyc), 39);
    step(); step(); step();

    // Idle hold.
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_rvalid", 32'(rvalid), 0);
      chk("idle_dwe", 32'(dwe), 0);
    end

    // Reset sampled in ACCESS of a write: no rvalid, pointer back to start.
    set_req(0, 1'b1, 32'h80, 32'hFF, 4'b1111);
    step();
    chk("rmid_gnt", 32'(gnt), 32'b01);
    chk("rmid_dwe", 32'(dwe), 32'hF);
    reset = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'b0);
    step();
    reset = 1'b0;
    chk("rmid_gnt0", 32'(gnt), 0);
    chk("rmid_rvalid0", 32'(rvalid), 0);
    chk("rmid_rdata0", rdata, 0);
    chk("rmid_daddr0", daddr, 0);
    chk("rmid_dwdata0", dwdata, 0);
    chk("rmid_dwe0", 32'(dwe), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rmid_no_rvalid", 32'(rvalid), 0);
    end
    set_req(0, 1'b1, 32'h10, 32'h0, 4'b0);
    set_req(1, 1'b1, 32'h14, 32'h0, 4'b0);
    step();
    chk("rmid_first_gnt", 32'(gnt), 32'b01);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'b0);
    done = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      step();
      if (gnt[1]) begin
        set_req(1, 1'b0, 32'h0, 32'h0, 4'b0);
        done = 1'b1;
      end
    end
    chk("rmid_second_gnt_seen", 32'(done), 1);
    req = '0;
    step(); step(); step();

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    @(negedge clk);
    snap_req   = '0;
    exp_g_prev = '0;
    last       = NREQ - 1;
    pend_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      snap_addr[i] = '0; snap_wdata[i] = '0; snap_we[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      // A new access may start in any cycle not directly following a grant.
      exp_rv = exp_g_prev;
      exp_g  = '0;
      w      = -1;
      if (exp_g_prev == '0 && snap_req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (last + k) % NREQ;
          if (w < 0 && snap_req[j]) w = j;
        end
        exp_g[w] = 1'b1;
      end
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv != '0) chk("rnd_rdata", rdata, pend_rdata);
      if (w >= 0) begin
        chk("rnd_daddr", daddr, snap_addr[w]);
        chk("rnd_dwdata", dwdata, snap_wdata[w]);
        chk("rnd_dwe", 32'(dwe), 32'(snap_we[w]));
        pend_rdata = (snap_we[w] == '0) ? ref_mem[snap_addr[w][9:2]] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (snap_we[w][b]) ref_mem[snap_addr[w][9:2]][b*8 +: 8] = snap_wdata[w][b*8 +: 8];
        last = w;
      end else begin
        chk("rnd_dwe_idle", 32'(dwe), 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        ra = 32'($urandom_range(0, 63)) << 2;
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, ra, $urandom, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
          else
            set_req(i, 1'b0, 32'h0, 32'h0, 4'b0);
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          set_req(i, 1'b1, ra, $urandom, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
        end
      end
      snap_req = req;
      for (int i = 0; i < NREQ; i++) begin
        snap_addr[i]  = req_addr[i*AW +: AW];
        snap_wdata[i] = req_wdata[i*DW +: DW];
        snap_we[i]    = req_we[i*4 +: 4];
      end
      exp_g_prev = exp_g;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (daddr/dwdata/dwe/drdata) of the single-cycle core between NREQ requesters, e.g. the CPU load/store path and a program loader or debug port.
- Round-robin arbitration with a req/gnt/rvalid handshake; one access in flight at a time.
- The memory side is driven from registers and is a drop-in for the core's existing dmem connection.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 = 4 bits.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester access request.
- req_addr  in  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_we  in  NREQ*4  flattened byte write enables; all-zero means read.
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted.
- rvalid  out  NREQ  one-hot, one-cycle pulse: access complete.
- rdata  out  DW  read data; meaningful only while rvalid is high.
- daddr  out  AW  memory address.
- dwdata  out  DW  memory write data.
- dwe  out  4  memory byte write enables.
- drdata  in  DW  memory read data, combinational from daddr.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, daddr=0, dwdata=0, dwe=0, state=IDLE, last winner pointer=NREQ-1 (requester 0 wins first).
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: memory port driven for exactly one cycle.
  - RESP: completion cycle.
- Arbitration occurs only at the closing edge of IDLE or RESP, and only when any req bit is high.
  - Winner = first requester with req=1 scanning from pointer+1 upward, wrapping modulo NREQ.
  - At that edge: latch the winner's addr/wdata/we into the daddr/dwdata/dwe registers, set gnt[winner]=1 for the next cycle, set pointer=winner, go to ACCESS.
  - If no req is high: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS, cycle T+1 when the request was sampled at the closing edge of T:
  - gnt[winner]=1 and the memory port carries the latched values.
  - The memory performs the write at the closing edge of T+1.
  - drdata is sampled into rdata at that same edge; for writes, rdata is loaded with 0.
  - Next state is RESP.
- RESP, cycle T+2:
  - rvalid[winner]=1 and rdata is valid.
  - dwe=0 (no repeated write); daddr and dwdata hold their values.
  - Arbitration for the next access happens at this cycle's edge.
- Latency and throughput:
  - Request sampled to rvalid = 2 cycles.
  - Sustained rate is one access per 2 cycles.
  - IDLE is entered only when no req is pending at the end of RESP.
- Handshake rules:
  - A requester holds req/addr/wdata/we stable until it observes gnt, then may drop or change them. The request is latched, so later input changes do not affect the access in flight.
  - A req still high in the cycle after gnt is treated as a new request.
  - At most one gnt bit and one rvalid bit are high in any cycle.
- Boundary cases:
  - All NREQ requesting continuously: grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 accesses.
  - Lone requester: wins every arbitration regardless of pointer.
  - reset in any state: at the next edge, return to IDLE with all outputs at reset values. The in-flight access produces no rvalid. dwe=0 from that edge, so a write pending in ACCESS is not committed if reset is sampled in ACCESS; the memory's own write at that edge is the memory's concern.
  - Misalignment: addresses and byte enables pass through unchecked; lane alignment is the requester's responsibility.
  - Address and data widths are not truncated or extended; values pass through as AW and DW bits.

Decomposition:
- Shared package/include: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default NREQ, AW and DW, and the byte-enable width constant.
- One natural sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner, winner index, any_req.
- The FSM and the output registers live in dmem_arbiter.

Test Plan:
- Single read: req0 with addr=0x100, we=0; memory holds 0xDEADBEEF at 0x100 -> gnt[0] at T+1 with daddr=0x100 and dwe=0; rvalid[0] at T+2 with rdata=0xDEADBEEF.
- Single write then readback: req1 with addr=0x40, we=4'b1111, wdata=0x12345678, then a read of 0x40 -> dwe=1111 only during ACCESS; the later rvalid[1] returns rdata=0x12345678.
- Simultaneous requests: req0 and req1 both raised from reset -> requester 0 granted first, requester 1 granted at the end of the following RESP; gnt at cycles 1 and 3, rvalid at cycles 2 and 4.
- Fairness: NREQ=2, both requesters re-request immediately after every gnt for 20 accesses -> grants strictly alternate 0,1,0,1,... and each requester receives 10.
- Reset mid-operation: assert reset while in ACCESS during a write of 0xFF at 0x80 -> next cycle all outputs are 0 and state is IDLE; no rvalid is ever produced; next arbitration grants requester 0 first.
- Idle hold and store byte lanes: no req for 5 cycles -> gnt, rvalid and dwe stay 0. Then a store with we=4'b0100 -> exactly one ACCESS cycle with dwe=0100, followed by dwe=0 in RESP.
